// File: rtl/hex_scan_display_if.sv
// rtl/hex_scan_display_if.sv - value/control inputs and multiplexed display outputs of hex_scan_display
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      lz_blank;
    logic                      blink_en;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      pending;
    logic                      frame_tick;

    modport master (
        output load, value, lz_blank, blink_en,
        input  seg, an, pending, frame_tick
    );

    modport slave (
        input  load, value, lz_blank, blink_en,
        output seg, an, pending, frame_tick
    );
endinterface

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - time-multiplexed hex 7-segment driver with frame-synchronous load, blanking and blink
module hex_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hex_scan_display_if.slave    bus
);
    localparam int CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_OFF  = 7'h7F;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         pend_val;
    logic [VW-1:0]         disp_val;
    logic                  pending;
    logic [FW-1:0]         frame_cnt;
    logic                  phase;
    logic [6:0]            seg_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic                  frame_tick_reg;

    logic                  tick;
    logic                  boundary;
    logic [IW-1:0]         idx_nxt;
    logic [VW-1:0]         disp_nxt;
    logic [FW-1:0]         frame_cnt_nxt;
    logic                  phase_nxt;
    logic [NUM_DIGITS:0]   zero_run;
    logic [3:0]            nib;
    logic                  lz_hide;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h18;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick     = (cnt == CNT_LAST);
        boundary = tick && (idx == IDX_LAST);
        idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

        // A load landing on the boundary edge bypasses pend_val so it shows from digit 0 of this frame
        disp_nxt = disp_val;
        if (boundary) begin
            if (bus.load)
                disp_nxt = bus.value;
            else if (pending)
                disp_nxt = pend_val;
        end

        frame_cnt_nxt = frame_cnt;
        phase_nxt     = phase;
        if (tick) begin
            if (!bus.blink_en) begin
                frame_cnt_nxt = '0;
                phase_nxt     = 1'b0;
            end else if (boundary) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt_nxt = '0;
                    phase_nxt     = ~phase;
                end else begin
                    frame_cnt_nxt = frame_cnt + 1'b1;
                end
            end
        end

        // zero_run[i] is set when nibbles i..NUM_DIGITS-1 of the next displayed value are all zero
        zero_run[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zero_run[i] = zero_run[i+1] && (disp_nxt[4*i +: 4] == 4'h0);

        nib     = 4'h0;
        lz_hide = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib     = disp_nxt[4*i +: 4];
                lz_hide = bus.lz_blank && (i != 0) && zero_run[i];
            end
        end

        if (bus.blink_en && phase_nxt)
            seg_nxt = SEG_OFF;
        else if (lz_hide)
            seg_nxt = SEG_OFF;
        else
            seg_nxt = hex7(nib);

        an_nxt = ~(AN_ONE << idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= IDX_LAST;
            pend_val       <= '0;
            disp_val       <= '0;
            pending        <= 1'b0;
            frame_cnt      <= '0;
            phase          <= 1'b0;
            seg_reg        <= SEG_OFF;
            an_reg         <= '1;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt            <= tick ? '0 : cnt + 1'b1;
            disp_val       <= disp_nxt;
            frame_cnt      <= frame_cnt_nxt;
            phase          <= phase_nxt;
            frame_tick_reg <= boundary;
            if (tick) begin
                idx     <= idx_nxt;
                seg_reg <= seg_nxt;
                an_reg  <= an_nxt;
            end
            if (bus.load && !boundary) begin
                pend_val <= bus.value;
                pending  <= 1'b1;
            end else if (boundary) begin
                pending  <= 1'b0;
            end
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.an         = an_reg;
    assign bus.pending    = pending;
    assign bus.frame_tick = frame_tick_reg;
endmodule
